// File: rtl/service_queue.sv
// Circular FIFO of (customer number, service time) entries with manual or tick-timed
// dequeue, occupancy count and sticky overflow/underflow flags.
module service_queue #(
    parameter int DT_SZ = 4,
    parameter int TM_SZ = 4,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [DT_SZ-1:0]                 dn,
    input  logic [TM_SZ-1:0]                 dt,
    input  logic                             re,
    input  logic                             auto,
    input  logic                             tick,
    input  logic                             clr,
    output logic [DT_SZ-1:0]                 qn,
    output logic [TM_SZ-1:0]                 qt,
    output logic [CNT_W-1:0]                 cnt,
    output logic                             full,
    output logic                             empty,
    output logic                             done,
    output logic [DT_SZ-1:0]                 pop_id,
    output logic                             ovf,
    output logic                             udf,
    output logic [DEPTH*(DT_SZ+TM_SZ)-1:0]   qdbg
);

    localparam int                ENT_W    = DT_SZ + TM_SZ;
    localparam logic [PTR_W-1:0]  LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [DT_SZ-1:0] num_q [DEPTH];
    logic [TM_SZ-1:0] tim_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic pop_man;
    logic pop_auto;
    logic pop;
    logic dec;
    logic push;
    logic ovf_set;
    logic udf_set;

    // DEPTH need not be a power of two, so wrap is explicit rather than by overflow
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign qn    = empty ? '0 : num_q[rd_ptr];
    assign qt    = empty ? '0 : tim_q[rd_ptr];

    // A head time of 0 or 1 both mean "leaves on this tick"
    assign pop_man  = !auto && re && !empty;
    assign pop_auto = auto && tick && !empty && (qt <= TM_SZ'(1));
    assign pop      = pop_man || pop_auto;
    assign dec      = auto && tick && !empty && (qt > TM_SZ'(1));
    assign push     = we && (!full || pop);
    assign ovf_set  = we && full && !pop;
    // A push into an empty queue absorbs a coincident pop request without an error
    assign udf_set  = !auto && re && empty && !we;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                num_q[i] <= '0;
                tim_q[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            pop_id <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push) begin
                num_q[wr_ptr] <= dn;
                tim_q[wr_ptr] <= dt;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (dec) begin
                tim_q[rd_ptr] <= qt - TM_SZ'(1);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                pop_id <= qn;
            end
            cnt  <= cnt + CNT_W'(push) - CNT_W'(pop);
            done <= pop;
            ovf  <= ovf_set || (ovf && !clr);
            udf  <= udf_set || (udf && !clr);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_dbg
        assign qdbg[i*ENT_W +: ENT_W] = {num_q[i], tim_q[i]};
    end

endmodule

// File: tb/tb_service_queue.sv
// Bench for service_queue (DEPTH=3): constant vector table, directed corner sequences,
// then random traffic compared against a queue-based reference model.
module tb_service_queue;

    localparam int DT = 4;
    localparam int TM = 4;
    localparam int D  = 3;
    localparam int PW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s, we_s, re_s, auto_s, tick_s, clr_s;
    logic [DT-1:0] dn_s;
    logic [TM-1:0] dt_s;
    logic [DT-1:0] qn, pop_id;
    logic [TM-1:0] qt;
    logic [CW-1:0] cnt;
    logic          full, empty, done, ovf, udf;
    logic [D*(DT+TM)-1:0] qdbg;

    service_queue #(.DT_SZ(DT), .TM_SZ(TM), .DEPTH(D), .PTR_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst_s), .we(we_s), .dn(dn_s), .dt(dt_s), .re(re_s),
        .auto(auto_s), .tick(tick_s), .clr(clr_s), .qn(qn), .qt(qt), .cnt(cnt),
        .full(full), .empty(empty), .done(done), .pop_id(pop_id), .ovf(ovf),
        .udf(udf), .qdbg(qdbg)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: logical queue plus physical slot image of the ring
    typedef struct {int n; int t;} ent_t;
    ent_t mq[$];
    int sn[D];
    int st[D];
    int npush = 0, npop = 0;
    int m_done = 0, m_pid = 0, m_ovf = 0, m_udf = 0;

    task automatic model_step();
        int ht;
        bit mempty, mfull, pop, dec, push, oset, uset;
        ent_t e;
        if (rst_s) begin
            mq.delete();
            for (int i = 0; i < D; i++) begin
                sn[i] = 0;
                st[i] = 0;
            end
            npush = 0; npop = 0;
            m_done = 0; m_pid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            mempty = (mq.size() == 0);
            mfull  = (mq.size() == D);
            ht     = mempty ? 0 : mq[0].t;
            if (auto_s) pop = tick_s && !mempty && ht <= 1;
            else        pop = re_s && !mempty;
            dec  = auto_s && tick_s && !mempty && ht > 1;
            push = we_s && (!mfull || pop);
            oset = we_s && mfull && !pop;
            uset = !auto_s && re_s && mempty && !we_s;
            m_done = pop ? 1 : 0;
            if (pop) begin
                e = mq.pop_front();
                m_pid = e.n;
                npop++;
            end
            if (dec) begin
                e = mq[0];
                e.t = ht - 1;
                mq[0] = e;
                st[npop % D] = ht - 1;
            end
            if (push) begin
                e.n = int'(dn_s);
                e.t = int'(dt_s);
                mq.push_back(e);
                sn[npush % D] = e.n;
                st[npush % D] = e.t;
                npush++;
            end
            m_ovf = (oset || (m_ovf != 0 && !clr_s)) ? 1 : 0;
            m_udf = (uset || (m_udf != 0 && !clr_s)) ? 1 : 0;
        end
    endtask

    task automatic check_model(input string tag);
        int en, et, eq, sz;
        sz = mq.size();
        en = (sz == 0) ? 0 : mq[0].n;
        et = (sz == 0) ? 0 : mq[0].t;
        eq = 0;
        for (int i = 0; i < D; i++) eq |= ((sn[i] << 4) | st[i]) << (8 * i);
        chk({tag, ".cnt"},    32'(cnt),    sz);
        chk({tag, ".full"},   32'(full),   (sz == D) ? 1 : 0);
        chk({tag, ".empty"},  32'(empty),  (sz == 0) ? 1 : 0);
        chk({tag, ".qn"},     32'(qn),     en);
        chk({tag, ".qt"},     32'(qt),     et);
        chk({tag, ".done"},   32'(done),   m_done);
        chk({tag, ".pop_id"}, 32'(pop_id), m_pid);
        chk({tag, ".ovf"},    32'(ovf),    m_ovf);
        chk({tag, ".udf"},    32'(udf),    m_udf);
        chk({tag, ".qdbg"},   32'(qdbg),   eq);
    endtask

    task automatic step(input int r, input int w, input int d, input int t,
                        input int e, input int a, input int k, input int c);
        rst_s  = r[0];
        we_s   = w[0];
        dn_s   = d[3:0];
        dt_s   = t[3:0];
        re_s   = e[0];
        auto_s = a[0];
        tick_s = k[0];
        clr_s  = c[0];
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        int rst, we, dn, dt, re, au, tk, clr;
        int cnt, qn, qt, done, pid, ovf, udf;
    } vec_t;
    vec_t vt[13];

    initial begin
        int exp_pid3[4];
        int exp_qt4[4], exp_done4[4], exp_pid4[4], exp_cnt4[4];
        int au;

        rst_s = 1'b1; we_s = 1'b0; re_s = 1'b0; auto_s = 1'b0;
        tick_s = 1'b0; clr_s = 1'b0; dn_s = '0; dt_s = '0;

        //        rst we dn dt re au tk clr  cnt qn qt dn pid ovf udf
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 1, 3, 0, 0, 0, 0,   1, 1, 3, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 2, 2, 0, 0, 0, 0,   2, 1, 3, 0, 0, 0, 0};
        vt[3]  = '{0, 1, 3, 1, 0, 0, 0, 0,   3, 1, 3, 0, 0, 0, 0};
        vt[4]  = '{0, 1, 4, 4, 0, 0, 0, 0,   3, 1, 3, 0, 0, 1, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 1,   3, 1, 3, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 1, 0, 0, 0,   2, 2, 2, 1, 1, 0, 0};
        vt[7]  = '{0, 0, 0, 0, 1, 0, 0, 0,   1, 3, 1, 1, 2, 0, 0};
        vt[8]  = '{0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 3, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 3, 0, 1};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 3, 0, 1};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 3, 0, 0};
        vt[12] = '{0, 1, 7, 2, 1, 0, 0, 0,   1, 7, 2, 0, 3, 0, 0};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].rst, vt[i].we, vt[i].dn, vt[i].dt, vt[i].re, vt[i].au, vt[i].tk, vt[i].clr);
            chk($sformatf("v%0d.cnt", i),    32'(cnt),    vt[i].cnt);
            chk($sformatf("v%0d.full", i),   32'(full),   (vt[i].cnt == D) ? 1 : 0);
            chk($sformatf("v%0d.empty", i),  32'(empty),  (vt[i].cnt == 0) ? 1 : 0);
            chk($sformatf("v%0d.qn", i),     32'(qn),     vt[i].qn);
            chk($sformatf("v%0d.qt", i),     32'(qt),     vt[i].qt);
            chk($sformatf("v%0d.done", i),   32'(done),   vt[i].done);
            chk($sformatf("v%0d.pop_id", i), 32'(pop_id), vt[i].pid);
            chk($sformatf("v%0d.ovf", i),    32'(ovf),    vt[i].ovf);
            chk($sformatf("v%0d.udf", i),    32'(udf),    vt[i].udf);
            check_model($sformatf("v%0d", i));
        end

        // Full queue with simultaneous push/pop, pointers wrapping twice
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, i, i, 0, 0, 0, 0);
        check_model("s3.fill");
        exp_pid3 = '{1, 2, 3, 5};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5 + i, 5 + i, 1, 0, 0, 0);
            chk($sformatf("s3.cnt%0d", i),    32'(cnt),    3);
            chk($sformatf("s3.done%0d", i),   32'(done),   1);
            chk($sformatf("s3.pop_id%0d", i), 32'(pop_id), exp_pid3[i]);
            check_model($sformatf("s3.%0d", i));
        end
        chk("s3.qn", 32'(qn), 6);
        chk("s3.qdbg", 32'(qdbg), 32'h0077_6688);

        // Auto countdown
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 3, 0, 1, 0, 0);
        step(0, 1, 2, 1, 0, 1, 0, 0);
        chk("s4.qt0", 32'(qt), 3);
        chk("s4.cnt0", 32'(cnt), 2);
        exp_qt4   = '{2, 1, 1, 0};
        exp_done4 = '{0, 0, 1, 1};
        exp_pid4  = '{0, 0, 1, 2};
        exp_cnt4  = '{2, 2, 1, 0};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1, 1, 0);
            chk($sformatf("s4.qt%0d", i + 1),   32'(qt),     exp_qt4[i]);
            chk($sformatf("s4.done%0d", i + 1), 32'(done),   exp_done4[i]);
            chk($sformatf("s4.pid%0d", i + 1),  32'(pop_id), exp_pid4[i]);
            chk($sformatf("s4.cnt%0d", i + 1),  32'(cnt),    exp_cnt4[i]);
            check_model($sformatf("s4.%0d", i + 1));
        end

        // Zero service time, tick on empty, re ignored in auto
        step(0, 1, 9, 0, 0, 1, 0, 0);
        chk("s5.qn", 32'(qn), 9);
        chk("s5.qt", 32'(qt), 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("s5.done", 32'(done), 1);
        chk("s5.pid", 32'(pop_id), 9);
        chk("s5.empty", 32'(empty), 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("s5.idle_done", 32'(done), 0);
        chk("s5.idle_cnt", 32'(cnt), 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("s5.re_udf", 32'(udf), 0);
        chk("s5.re_done", 32'(done), 0);
        check_model("s5");

        // Reset mid-operation overrides a coincident pop
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, i, 4, 0, 0, 0, 0);
        step(0, 1, 4, 4, 0, 0, 0, 0);
        chk("s6.ovf_pre", 32'(ovf), 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("s6.cnt_pre", 32'(cnt), 2);
        chk("s6.done_pre", 32'(done), 1);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        chk("s6.cnt", 32'(cnt), 0);
        chk("s6.empty", 32'(empty), 1);
        chk("s6.qdbg", 32'(qdbg), 0);
        chk("s6.done", 32'(done), 0);
        chk("s6.ovf", 32'(ovf), 0);
        chk("s6.udf", 32'(udf), 0);
        chk("s6.pop_id", 32'(pop_id), 0);
        check_model("s6");

        // Random traffic against the model
        au = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) au = 1 - au;
            step(($urandom_range(0, 63) == 0) ? 1 : 0,
                 ($urandom_range(0, 1) == 1) ? 1 : 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 4)),
                 ($urandom_range(0, 4) < 2) ? 1 : 0,
                 au,
                 ($urandom_range(0, 1) == 1) ? 1 : 0,
                 ($urandom_range(0, 15) == 0) ? 1 : 0);
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
